bin_to_bcd_seq: RTL and testbench



---
 rtl/bin_to_bcd_if.sv | 24 ++
 rtl/bin_to_bcd_seq.sv | 133 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_if.sv
// Start/done handshake and result bus between a conversion controller and bin_to_bcd_seq.
// The master requests conversions and the slave, the converter, returns BCD digits.
interface bin_to_bcd_if #(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3
);
  logic                  start;
  logic [BIN_WIDTH-1:0]  bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;
  logic [DIGITS-1:0]     blank_mask;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow, blank_mask
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow, blank_mask
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blank mask is enabled with `define BIN_TO_BCD_BLANK_EN.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3
) (
  input  logic        clk,
  input  logic        reset,
  bin_to_bcd_if.slave bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [BCD_W-1:0] NINES = {DIGITS{4'h9}};

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CONV = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [BIN_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W:0]       acc_q, acc_d, acc_adj, acc_shift;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic                 last_step;

  assign last_step = (state_q == CONV) && (cnt_q == CNT_W'(1));

  // Add-3 correction on every full nibble before it is doubled.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // The spare top bit is sticky: once a carry leaves the top digit the value
  // is known to exceed 10^DIGITS-1, since the partial value only ever grows.
  assign acc_shift = {acc_adj[BCD_W] | acc_adj[BCD_W-1],
                      acc_adj[BCD_W-2:0],
                      shift_q[BIN_WIDTH-1]};

  always_comb begin
    // NOTE: every next-state signal takes its default first, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d = bus.bin_in;
          acc_d   = '0;
          cnt_d   = CNT_W'(BIN_WIDTH);
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        acc_d   = acc_shift;
        shift_d = {shift_q[BIN_WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q - CNT_W'(1);
        if (last_step) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
          ovf_d   = acc_shift[BCD_W];
          bcd_d   = acc_shift[BCD_W] ? NINES : acc_shift[BCD_W-1:0];
        end
      end
    endcase
  end

  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      bcd_q   <= bcd_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;

`ifdef BIN_TO_BCD_BLANK_EN
  // Leading-zero flags: a digit blanks only if it and all digits above are zero.
  function automatic logic [DIGITS-1:0] blank_of(input logic [BCD_W-1:0] digits);
    logic lead;
    blank_of = '0;
    lead     = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead        = lead & (digits[4*i +: 4] == 4'd0);
      blank_of[i] = lead;
    end
  endfunction

  logic [DIGITS-1:0] blank_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blank_q <= '0;
    end else if (last_step) begin
      blank_q <= acc_shift[BCD_W] ? '0 : blank_of(acc_shift[BCD_W-1:0]);
    end
  end

  assign bus.blank_mask = blank_q;
`else
  assign bus.blank_mask = '0;
`endif
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed handshake cases plus a sweep
// and random values compared against an arithmetic decimal reference model.
module tb_bin_to_bcd_seq;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  bin_to_bcd_if #(.BIN_WIDTH(8), .DIGITS(3)) if3 ();
  bin_to_bcd_if #(.BIN_WIDTH(8), .DIGITS(2)) if2 ();

  bin_to_bcd_seq #(.BIN_WIDTH(8), .DIGITS(3)) u3 (.clk(clk), .reset(reset), .bus(if3));
  bin_to_bcd_seq #(.BIN_WIDTH(8), .DIGITS(2)) u2 (.clk(clk), .reset(reset), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain decimal arithmetic.
  function automatic int pow10(input int nd);
    int p = 1;
    for (int i = 0; i < nd; i++) p *= 10;
    return p;
  endfunction

  function automatic logic [11:0] bcd_ref(input int v, input int nd);
    logic [11:0] r = '0;
    int          x = v;
    if (v >= pow10(nd)) begin
      for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'd9;
      return r;
    end
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [2:0] blank_ref(input int v, input int nd);
    logic [2:0] m = '0;
`ifdef BIN_TO_BCD_BLANK_EN
    int  x = v;
    int  d [3];
    bit  lead = 1'b1;
    if (v >= pow10(nd)) return '0;
    for (int i = 0; i < 3; i++) begin
      d[i] = x % 10;
      x    = x / 10;
    end
    for (int i = nd - 1; i >= 1; i--) begin
      lead = lead && (d[i] == 0);
      m[i] = lead;
    end
`endif
    return m;
  endfunction

  // Full conversion on the 3-digit unit; bin_in is scrambled after capture.
  task automatic run3(input int v);
    int n = 0;
    bit seen = 1'b0;
    if3.start  = 1'b1;
    if3.bin_in = v[7:0];
    tick();
    if3.start  = 1'b0;
    if3.bin_in = 8'($urandom);
    while (!seen && n < 20) begin
      tick();
      n++;
      if (if3.done) seen = 1'b1;
    end
    check("done3_seen", seen, 1);
    check("latency3", n, 8);
    check("bcd3", if3.bcd_out, bcd_ref(v, 3));
    check("ovf3", if3.overflow, 0);
    check("blank3", if3.blank_mask, blank_ref(v, 3));
  endtask

  task automatic run2(input int v);
    int n = 0;
    bit seen = 1'b0;
    if2.start  = 1'b1;
    if2.bin_in = v[7:0];
    tick();
    if2.start  = 1'b0;
    if2.bin_in = 8'($urandom);
    while (!seen && n < 20) begin
      tick();
      n++;
      if (if2.done) seen = 1'b1;
    end
    check("done2_seen", seen, 1);
    check("latency2", n, 8);
    check("bcd2", if2.bcd_out, {4'd0, bcd_ref(v, 2)[7:0]});
    check("ovf2", if2.overflow, (v >= 100) ? 1 : 0);
    check("blank2", if2.blank_mask, {1'b0, blank_ref(v, 2)[1:0]});
  endtask

  // Every accumulator nibble must stay a valid decimal digit.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      for (int i = 0; i < 3; i++) check("nibble3", u3.acc_q[4*i +: 4] <= 4'd9, 1);
      for (int i = 0; i < 2; i++) check("nibble2", u2.acc_q[4*i +: 4] <= 4'd9, 1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dones;
    logic [11:0] cap;

    reset      = 1'b1;
    if3.start  = 1'b0;
    if3.bin_in = '0;
    if2.start  = 1'b0;
    if2.bin_in = '0;
    #3 reset = 1'b0;
    #1;
    check("rst_busy", if3.busy, 0);
    check("rst_done", if3.done, 0);
    check("rst_bcd", if3.bcd_out, 0);
    check("rst_ovf", if3.overflow, 0);
    check("rst_blank", if3.blank_mask, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // 255 with cycle-exact busy/done timing.
    if3.start  = 1'b1;
    if3.bin_in = 8'd255;
    tick();
    if3.start = 1'b0;
    check("busy_k", if3.busy, 1);
    for (int j = 1; j < 8; j++) begin
      tick();
      check("busy_mid", if3.busy, 1);
      check("done_mid", if3.done, 0);
    end
    tick();
    check("done_255", if3.done, 1);
    check("busy_end", if3.busy, 0);
    check("bcd_255", if3.bcd_out, 12'h255);
    check("ovf_255", if3.overflow, 0);
    check("blank_255", if3.blank_mask, blank_ref(255, 3));
    tick();
    check("done_pulse", if3.done, 0);
    check("bcd_hold", if3.bcd_out, 12'h255);

    // 0 then 7 back-to-back with start held during the done cycle.
    if3.start  = 1'b1;
    if3.bin_in = 8'd0;
    tick();
    if3.start = 1'b0;
    repeat (8) tick();
    check("done_0", if3.done, 1);
    check("bcd_0", if3.bcd_out, 12'h000);
    check("blank_0", if3.blank_mask, blank_ref(0, 3));
    if3.start  = 1'b1;
    if3.bin_in = 8'd7;
    tick();
    if3.start = 1'b0;
    check("b2b_busy", if3.busy, 1);
    check("b2b_done", if3.done, 0);
    n = 0;
    while (!if3.done && n < 20) begin
      tick();
      n++;
    end
    check("b2b_period", n, 8);
    check("bcd_7", if3.bcd_out, 12'h007);
    check("blank_7", if3.blank_mask, blank_ref(7, 3));
    tick();

    // 100, with a second start 3 cycles later that must be ignored.
    if3.start  = 1'b1;
    if3.bin_in = 8'd100;
    tick();
    if3.start  = 1'b0;
    if3.bin_in = 8'd42;
    tick();
    tick();
    if3.start = 1'b1;
    tick();
    if3.start = 1'b0;
    dones = 0;
    n     = 0;
    cap   = '0;
    for (int j = 4; j <= 25; j++) begin
      tick();
      if (if3.done) begin
        dones++;
        n   = j;
        cap = if3.bcd_out;
      end
    end
    check("ign_dones", dones, 1);
    check("ign_latency", n, 8);
    check("ign_bcd", cap, 12'h100);
    check("ign_blank", if3.blank_mask, blank_ref(100, 3));
    check("ign_idle", if3.busy, 0);

    // Two-digit unit: overflow saturates, then an in-range value clears it.
    run2(150);
    check("ovf2_150", if2.bcd_out, 12'h099);
    run2(99);

    // Reset asserted in the 4th CONV cycle of a conversion of 200.
    if3.start  = 1'b1;
    if3.bin_in = 8'd200;
    tick();
    if3.start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("mid_busy", if3.busy, 0);
    check("mid_done", if3.done, 0);
    check("mid_bcd", if3.bcd_out, 0);
    check("mid_ovf", if3.overflow, 0);
    check("mid_blank", if3.blank_mask, 0);
    tick();
    reset = 1'b1;
    dones = 0;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (if3.done) dones++;
    end
    check("mid_no_done", dones, 0);
    run3(9);
    check("after_rst_9", if3.bcd_out, 12'h009);

    // Exhaustive sweep, then random values on the two-digit unit.
    for (int v = 0; v < 256; v++) begin
      run3(v);
      repeat ($urandom_range(0, 2)) tick();
    end
    for (int j = 0; j < 64; j++) begin
      run2(int'($urandom_range(0, 255)));
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
